pipelined_execute_writeback: RTL and testbench
==============================================

Name: pipelined_execute_writeback

Overview:
- Parametrised two-stage execute/writeback unit for the single-cycle core's successor.
- Supersedes the 8-bit LI/ADDI-only combinational execute block.
- Contains the register file, an ALU with eight opcodes, a registered EX/WB stage, and WB-to-EX forwarding.
- Downstream stall control freezes the pipeline.

Parameters:
- DATA_W, 8, datapath and register width.
- REG_ADDR_W, 3, register-address width; the file holds 2**REG_ADDR_W registers.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  freezes EX/WB and blocks regfile writes.
- in_valid  input  1  the instruction fields are valid this cycle.
- in_ready  output  1  equals ~stall; an instruction is accepted when in_valid & in_ready.
- opcode  input  3  operation select (see Behaviour).
- rs_addr  input  REG_ADDR_W  first source register.
- rt_addr  input  REG_ADDR_W  second source register.
- rd_addr  input  REG_ADDR_W  destination register.
- imm_data  input  DATA_W  immediate operand.
- wb_valid  output  1  the EX/WB register holds a writing instruction.
- wb_addr  output  REG_ADDR_W  destination held in EX/WB.
- wb_data  output  DATA_W  result held in EX/WB.
- carry  output  1  registered carry/borrow of the instruction in EX/WB.
- dbg_addr  input  REG_ADDR_W  debug read address.
- dbg_data  output  DATA_W  raw register-file content at dbg_addr (combinational, no forwarding).

Behaviour:
- Reset: asynchronous and active-high; clk and reset are the only clock/reset.
  - All registers cleared to 0; wb_valid=0, wb_addr=0, wb_data=0, carry=0.
  - Reset asserted mid-operation discards the in-flight EX/WB instruction; its write never happens.
- Opcodes (all arithmetic modulo 2**DATA_W):
  - 0 LI: rd = imm.
  - 1 ADDI: rd = rs + imm.
  - 2 ADD: rd = rs + rt.
  - 3 SUB: rd = rs - rt.
  - 4 AND: rd = rs & rt.
  - 5 OR: rd = rs | rt.
  - 6 XOR: rd = rs ^ rt.
  - 7 NOP: no write.
- carry:
  - ADD/ADDI: carry-out of the DATA_W+1-bit sum.
  - SUB: 1 when rs < rt unsigned (borrow).
  - All other ops: 0.
- Register 0:
  - Reads always return 0.
  - Writes to r0 set wb_valid=0.
  - r0 is never forwarded.
- Pipeline timing:
  - EX is combinational on cycle N, when the instruction is accepted.
  - At edge N+1, EX/WB loads {wb_valid, wb_addr, wb_data, carry}; the result is visible on the wb_* outputs during cycle N+1.
  - At the next edge with stall=0, the register file writes wb_data to wb_addr if wb_valid=1.
  - Latency from accept to architectural update is 2 edges.
- EX/WB load rule:
  - When stall=0, EX/WB loads every edge.
  - No accepted instruction, NOP, or rd=0 loads wb_valid=0 (bubble).
  - When stall=1, EX/WB holds its value, no regfile write occurs, and in_ready=0.
- Forwarding:
  - When wb_valid=1 and wb_addr equals rs_addr (or rt_addr) and that address is nonzero, EX uses wb_data instead of the regfile value for that operand.
  - Both operands may be forwarded simultaneously.
- Simultaneous write and new accept on the same edge: the write commits and EX/WB loads the new result. No hazard, because the new instruction already received the forwarded value.
- Stall release: the held EX/WB write commits exactly once, on the first edge with stall=0.
- dbg_data reflects the register file only, so it lags a write by up to one cycle relative to wb_data.

Test Plan:
- Reset, then LI r1,0x05 accepted at cycle 0 -> cycle 1: wb_valid=1, wb_addr=1, wb_data=0x05; after edge 2: dbg_addr=1 reads 0x05.
- LI r1,0x05; next cycle ADDI r2,r1,0x03 back-to-back -> forwarding yields wb_data=0x08 for r2; r2=0x08 in the regfile.
- ADD with r3=0xF0, r4=0x20 -> wb_data=0x10, carry=1. SUB with r4=0x20, r3=0xF0 -> wb_data=0x30, carry=1. SUB 0x20-0x10 -> carry=0.
- LI r1,0xAA, then assert stall for 3 cycles -> in_ready=0, wb_* held, dbg r1 unchanged. Release stall -> r1=0xAA written once; the next LI proceeds normally.
- LI r0,0x77, then ADD r5,r0,r0 -> first instruction: wb_valid=0. Second: wb_data=0x00 (no forwarding of r0); dbg r0=0.
- Pulse reset while LI r6,0x3C is held in EX/WB -> wb_valid=0 immediately (asynchronous); r6=0 after reset; all registers read 0.

Source files
------------

// File: rtl/pipelined_execute_writeback_if.sv
// Instruction-issue, writeback-observation and debug-read signals of the
// two-stage execute/writeback unit.
interface pipelined_execute_writeback_if #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
);
  logic                  stall;
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            opcode;
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0]     imm_data;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  carry;
  logic [REG_ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0]     dbg_data;

  modport master (
    output stall, in_valid, opcode, rs_addr, rt_addr, rd_addr, imm_data, dbg_addr,
    input  in_ready, wb_valid, wb_addr, wb_data, carry, dbg_data
  );

  modport slave (
    input  stall, in_valid, opcode, rs_addr, rt_addr, rd_addr, imm_data, dbg_addr,
    output in_ready, wb_valid, wb_addr, wb_data, carry, dbg_data
  );
endinterface

// File: rtl/pipelined_execute_writeback.sv
// Two-stage execute/writeback unit: register file, eight-op ALU, registered
// EX/WB stage with WB-to-EX forwarding, and a downstream stall that freezes it.
module pipelined_execute_writeback #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
) (
  input logic clk,
  input logic reset,
  pipelined_execute_writeback_if.slave bus
);
  localparam int NREG = 2 ** REG_ADDR_W;

  localparam logic [2:0] OP_LI   = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  // Returns {carry, result}; the top bit is the carry-out or borrow.
  function automatic logic [DATA_W:0] alu(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] imm
  );
    logic [DATA_W:0] r;
    case (op)
      OP_LI:   r = {1'b0, imm};
      OP_ADDI: r = {1'b0, a} + {1'b0, imm};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a < b), a - b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0]     regs [NREG];
  logic                  vld_p1;
  logic [REG_ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0]     data_p1;
  logic                  carry_p1;

  logic                  accept_p0;
  logic                  writes_p0;
  logic [DATA_W-1:0]     op_a_p0;
  logic [DATA_W-1:0]     op_b_p0;
  logic [DATA_W:0]       alu_p0;

  assign bus.in_ready = ~bus.stall;
  assign accept_p0    = bus.in_valid & ~bus.stall;
  assign writes_p0    = accept_p0 && (bus.opcode != OP_NOP) && (bus.rd_addr != '0);

  // Stage 0 (EX): operand fetch with r0 forced to zero and forwarding from EX/WB.
  always_comb begin
    op_a_p0 = '0;
    op_b_p0 = '0;
    if (bus.rs_addr != '0)
      op_a_p0 = (vld_p1 && addr_p1 == bus.rs_addr) ? data_p1 : regs[bus.rs_addr];
    if (bus.rt_addr != '0)
      op_b_p0 = (vld_p1 && addr_p1 == bus.rt_addr) ? data_p1 : regs[bus.rt_addr];
  end

  assign alu_p0 = alu(bus.opcode, op_a_p0, op_b_p0, bus.imm_data);

  // Stage 1 (EX/WB): loads every unstalled edge; a bubble carries vld_p1=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      data_p1  <= '0;
      carry_p1 <= 1'b0;
    end else if (!bus.stall) begin
      vld_p1   <= writes_p0;
      addr_p1  <= bus.rd_addr;
      data_p1  <= alu_p0[DATA_W-1:0];
      carry_p1 <= alu_p0[DATA_W];
    end
  end

  // Writeback: a held EX/WB entry commits once, on the first unstalled edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (!bus.stall && vld_p1) begin
      regs[addr_p1] <= data_p1;
    end
  end

  assign bus.wb_valid = vld_p1;
  assign bus.wb_addr  = addr_p1;
  assign bus.wb_data  = data_p1;
  assign bus.carry    = carry_p1;
  assign bus.dbg_data = regs[bus.dbg_addr];
endmodule

// File: tb/tb_pipelined_execute_writeback.sv
// Bench for pipelined_execute_writeback: directed scenarios then random traffic,
// checked against a sequential instruction-level model.
module tb_pipelined_execute_writeback;
  localparam int DW = 8;
  localparam int AW = 3;

  localparam logic [2:0] LI = 3'd0, ADDI = 3'd1, ADD = 3'd2, SUB = 3'd3;
  localparam logic [2:0] NOP = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  // arch: state as seen by the next instruction; committed: register file contents.
  logic [DW-1:0] arch      [8];
  logic [DW-1:0] committed [8];
  logic          exp_vld;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          exp_c;

  pipelined_execute_writeback_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

  pipelined_execute_writeback #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dbg(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bus.dbg_addr = a;
    #1;
    check(tag, {24'd0, bus.dbg_data}, {24'd0, exp});
  endtask

  task automatic ref_exec(input logic [2:0] op, input int a, input int b, input int imm,
                          output logic [DW-1:0] res, output logic c);
    int r;
    c = 1'b0;
    case (op)
      0: r = imm;
      1: begin r = a + imm; c = (r > 255); end
      2: begin r = a + b;   c = (r > 255); end
      3: begin r = a - b;   c = (a < b); if (r < 0) r += 256; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = 0;
    endcase
    res = DW'(r % 256);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      arch[i] = '0;
      committed[i] = '0;
    end
    exp_vld = 1'b0; exp_addr = '0; exp_data = '0; exp_c = 1'b0;
  endtask

  // Starts just after a rising edge, ends 1 time unit after the next one.
  task automatic step(input logic v, input logic [2:0] op, input logic [AW-1:0] rs,
                      input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                      input logic [DW-1:0] imm, input logic st);
    logic [AW-1:0] da;
    logic [DW-1:0] res;
    logic          c;
    da = AW'($urandom_range(0, 7));
    bus.in_valid = v; bus.opcode = op; bus.rs_addr = rs; bus.rt_addr = rt;
    bus.rd_addr = rd; bus.imm_data = imm; bus.stall = st; bus.dbg_addr = da;
    @(negedge clk);
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, ~st});
    check("dbg_step", {24'd0, bus.dbg_data}, {24'd0, committed[da]});
    @(posedge clk);
    if (!st) begin
      if (exp_vld) committed[exp_addr] = exp_data;
      exp_vld = 1'b0;
      if (v) begin
        ref_exec(op, int'(arch[rs]), int'(arch[rt]), int'(imm), res, c);
        if (op != NOP && rd != 0) begin
          exp_vld = 1'b1; exp_addr = rd; exp_data = res; exp_c = c;
          arch[rd] = res;
        end
      end
    end
    #1;
    check("wb_valid", {31'd0, bus.wb_valid}, {31'd0, exp_vld});
    if (exp_vld) begin
      check("wb_addr", {29'd0, bus.wb_addr}, {29'd0, exp_addr});
      check("wb_data", {24'd0, bus.wb_data}, {24'd0, exp_data});
      check("carry", {31'd0, bus.carry}, {31'd0, exp_c});
    end
  endtask

  initial begin
    clear_model();
    bus.stall = 1'b0; bus.in_valid = 1'b0; bus.opcode = NOP; bus.rs_addr = '0;
    bus.rt_addr = '0; bus.rd_addr = '0; bus.imm_data = '0; bus.dbg_addr = '0;
    #25 reset = 1'b0;
    @(posedge clk); #1;

    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_wb_addr", {29'd0, bus.wb_addr}, 32'd0);
    check("rst_wb_data", {24'd0, bus.wb_data}, 32'd0);
    check("rst_carry", {31'd0, bus.carry}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) check_dbg("rst_dbg", AW'(i), 8'h00);

    // LI then back-to-back ADDI through forwarding
    step(1, LI, 0, 0, 1, 8'h05, 0);
    check("li_data", {24'd0, bus.wb_data}, 32'h05);
    step(1, ADDI, 1, 0, 2, 8'h03, 0);
    check("fwd_addi", {24'd0, bus.wb_data}, 32'h08);
    step(0, NOP, 0, 0, 0, 8'h00, 0);
    check_dbg("dbg_r1", 1, 8'h05);
    step(0, NOP, 0, 0, 0, 8'h00, 0);
    check_dbg("dbg_r2", 2, 8'h08);

    // ADD / SUB carry and borrow
    step(1, LI, 0, 0, 3, 8'hF0, 0);
    step(1, LI, 0, 0, 4, 8'h20, 0);
    step(1, ADD, 3, 4, 5, 8'h00, 0);
    check("add_data", {24'd0, bus.wb_data}, 32'h10);
    check("add_carry", {31'd0, bus.carry}, 32'd1);
    step(1, SUB, 4, 3, 6, 8'h00, 0);
    check("sub_data", {24'd0, bus.wb_data}, 32'h30);
    check("sub_borrow", {31'd0, bus.carry}, 32'd1);
    step(1, LI, 0, 0, 7, 8'h10, 0);
    step(1, SUB, 4, 7, 6, 8'h00, 0);
    check("sub2_data", {24'd0, bus.wb_data}, 32'h10);
    check("sub2_borrow", {31'd0, bus.carry}, 32'd0);

    // Stall holds EX/WB and blocks the write until release
    step(1, LI, 0, 0, 1, 8'hAA, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, LI, 0, 0, 3, 8'h99, 1);
      check("stall_hold", {24'd0, bus.wb_data}, 32'hAA);
      check_dbg("stall_dbg_r1", 1, 8'h05);
    end
    step(0, NOP, 0, 0, 0, 8'h00, 0);
    check_dbg("release_r1", 1, 8'hAA);
    step(1, LI, 0, 0, 2, 8'h11, 0);
    check("post_stall_li", {24'd0, bus.wb_data}, 32'h11);

    // Register 0 is never written nor forwarded
    step(1, LI, 0, 0, 0, 8'h77, 0);
    check("r0_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    step(1, ADD, 0, 0, 5, 8'h00, 0);
    check("r0_no_fwd", {24'd0, bus.wb_data}, 32'h00);
    step(0, NOP, 0, 0, 0, 8'h00, 0);
    check_dbg("dbg_r0", 0, 8'h00);

    // Asynchronous reset discards the in-flight write
    step(1, LI, 0, 0, 6, 8'h3C, 0);
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("async_rst_vld", {31'd0, bus.wb_valid}, 32'd0);
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 8; i++) check_dbg("post_rst_dbg", AW'(i), 8'h00);
    @(posedge clk); #1;

    // Random traffic with random stalls
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0));
    end
    step(0, NOP, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) check_dbg("final_dbg", AW'(i), committed[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
